// File: rtl/proc_mem_responder.sv
// Word-array memory endpoint for the val/rdy processor memory protocol.
// Optional random request stalls: define PROC_MEM_RESPONDER_STALL_EN.
module proc_mem_responder #(
    parameter int          p_num_words  = 256,
    parameter int          p_q_depth    = 2,
    parameter logic [15:0] p_stall_seed = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memreq_val,
    output logic        memreq_rdy,
    input  logic [2:0]  memreq_type,
    input  logic [7:0]  memreq_opaque,
    input  logic [31:0] memreq_addr,
    input  logic [1:0]  memreq_len,
    input  logic [31:0] memreq_data,
    output logic        memresp_val,
    input  logic        memresp_rdy,
    output logic [2:0]  memresp_type,
    output logic [7:0]  memresp_opaque,
    output logic [1:0]  memresp_test,
    output logic [1:0]  memresp_len,
    output logic [31:0] memresp_data
);
    localparam int AW = $clog2(p_num_words);
    localparam int PW = $clog2(p_q_depth);
    localparam int CW = $clog2(p_q_depth + 1);
    localparam logic [CW-1:0] QDEPTH = CW'(p_q_depth);
    localparam logic [PW-1:0] PLAST  = PW'(p_q_depth - 1);

    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  opaque;
        logic [1:0]  len;
        logic [31:0] data;
    } resp_t;

    logic [31:0]   mem_q [p_num_words];
    resp_t         rq_q  [p_q_depth];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [AW-1:0] idx;
    logic [1:0]    off;
    logic [2:0]    nbytes, lane_end;
    logic [3:0]    be;
    logic [31:0]   wdata, rword, rdata;
    logic          is_wr, space, req_fire, resp_fire;
    resp_t         new_resp, head;

    logic unused_addr;
    assign unused_addr = ^memreq_addr[31:AW+2];

    always_comb begin
        idx      = memreq_addr[AW+1:2];
        off      = memreq_addr[1:0];
        nbytes   = (memreq_len == 2'd0) ? 3'd4 : {1'b0, memreq_len};
        lane_end = {1'b0, off} + nbytes;
        for (int b = 0; b < 4; b++)
            be[b] = (3'(b) >= {1'b0, off}) && (3'(b) < lane_end);
        wdata = memreq_data << {off, 3'b000};
        // Right shift zero-fills lanes past byte 3, so only the length mask is needed.
        rword = mem_q[idx] >> {off, 3'b000};
        rdata = '0;
        for (int k = 0; k < 4; k++)
            if (3'(k) < nbytes) rdata[8*k +: 8] = rword[8*k +: 8];
        is_wr = (memreq_type == 3'd1) || (memreq_type == 3'd2);
        new_resp.typ    = memreq_type;
        new_resp.opaque = memreq_opaque;
        new_resp.len    = memreq_len;
        new_resp.data   = (memreq_type == 3'd0) ? rdata : 32'd0;
    end

    assign space = (cnt_q < QDEPTH);

`ifdef PROC_MEM_RESPONDER_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;
    always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= p_stall_seed;
        else       lfsr_q <= lfsr_d;
    end
    assign memreq_rdy = !reset && space && !lfsr_q[0];
`else
    localparam logic [15:0] unused_seed = p_stall_seed;
    assign memreq_rdy = !reset && space;
`endif

    assign memresp_val = !reset && (cnt_q != '0);
    assign req_fire    = memreq_val && memreq_rdy;
    assign resp_fire   = memresp_val && memresp_rdy;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (req_fire)  wptr_d = (wptr_q == PLAST) ? '0 : wptr_q + 1'b1;
        if (resp_fire) rptr_d = (rptr_q == PLAST) ? '0 : rptr_q + 1'b1;
        case ({req_fire, resp_fire})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Queue payload and array are never reset; validity comes from cnt_q alone.
    always_ff @(posedge clk) begin
        if (req_fire) rq_q[wptr_q] <= new_resp;
    end

    always_ff @(posedge clk) begin
        if (req_fire && is_wr)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
    end

    always_comb begin
        head           = rq_q[rptr_q];
        memresp_type   = memresp_val ? head.typ    : 3'd0;
        memresp_opaque = memresp_val ? head.opaque : 8'd0;
        memresp_len    = memresp_val ? head.len    : 2'd0;
        memresp_data   = memresp_val ? head.data   : 32'd0;
        memresp_test   = 2'd0;
    end
endmodule

// File: tb/tb_proc_mem_responder.sv
// Randomized + directed bench for proc_mem_responder against a byte-level memory/queue model.
module tb_proc_mem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        memreq_val, memreq_rdy;
    logic [2:0]  memreq_type;
    logic [7:0]  memreq_opaque;
    logic [31:0] memreq_addr;
    logic [1:0]  memreq_len;
    logic [31:0] memreq_data;
    logic        memresp_val, memresp_rdy;
    logic [2:0]  memresp_type;
    logic [7:0]  memresp_opaque;
    logic [1:0]  memresp_test;
    logic [1:0]  memresp_len;
    logic [31:0] memresp_data;

    proc_mem_responder dut (
        .clk(clk), .reset(reset),
        .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_type(memreq_type),
        .memreq_opaque(memreq_opaque), .memreq_addr(memreq_addr), .memreq_len(memreq_len),
        .memreq_data(memreq_data),
        .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_type(memresp_type),
        .memresp_opaque(memresp_opaque), .memresp_test(memresp_test), .memresp_len(memresp_len),
        .memresp_data(memresp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  t;
        logic [7:0]  op;
        logic [1:0]  len;
        logic [31:0] d;
    } rsp_t;

    int          checks = 0, failures = 0;
    int          cyc = 0;
    logic [31:0] mm [256];
    rsp_t        mq [$];
    logic [7:0]  pop_log [$];
    logic [31:0] act_data [256];
    bit          stop_rnd;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: byte-by-byte memory and an in-order response list.
    rsp_t        h, nr;
    int          nb, off, lane;
    logic [7:0]  w;
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_resp_val", 64'(memresp_val), 64'd0);
            chk("rst_req_rdy", 64'(memreq_rdy), 64'd0);
            mq.delete();
        end else begin
            chk("resp_val", 64'(memresp_val), 64'(mq.size() != 0));
            if (mq.size() != 0) begin
                h = mq[0];
                chk("resp_payload", 64'({memresp_type, memresp_opaque, memresp_test, memresp_len, memresp_data}),
                    64'({h.t, h.op, 2'b00, h.len, h.d}));
            end else
                chk("resp_idle_zero", 64'({memresp_type, memresp_opaque, memresp_test, memresp_len, memresp_data}), 64'd0);
`ifdef PROC_MEM_RESPONDER_STALL_EN
            if (mq.size() >= 2) chk("req_rdy_full", 64'(memreq_rdy), 64'd0);
`else
            chk("req_rdy", 64'(memreq_rdy), 64'(mq.size() < 2));
`endif
            if (mq.size() != 0 && memresp_rdy) begin
                pop_log.push_back(memresp_opaque);
                act_data[memresp_opaque] = memresp_data;
                void'(mq.pop_front());
            end
            if (memreq_val && memreq_rdy) begin
                nb  = (memreq_len == 0) ? 4 : int'(memreq_len);
                off = int'(memreq_addr[1:0]);
                w   = memreq_addr[9:2];
                nr.t = memreq_type; nr.op = memreq_opaque; nr.len = memreq_len; nr.d = 32'd0;
                for (int i = 0; i < nb; i++) begin
                    lane = off + i;
                    if (lane < 4) begin
                        if (memreq_type == 3'd0)
                            nr.d[8*i +: 8] = mm[w][8*lane +: 8];
                        else if (memreq_type == 3'd1 || memreq_type == 3'd2)
                            mm[w][8*lane +: 8] = memreq_data[8*i +: 8];
                    end
                end
                mq.push_back(nr);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [2:0] t, input logic [31:0] a, input logic [1:0] l,
                        input logic [31:0] d, input logic [7:0] op);
        int  n = 0;
        bit  done = 0;
        memreq_val = 1'b1; memreq_type = t; memreq_addr = a;
        memreq_len = l; memreq_data = d; memreq_opaque = op;
        while (!done && n < 50) begin
            @(negedge clk); done = memreq_rdy;
            @(posedge clk); #1; n++;
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL send_timeout actual=not_accepted required=accepted op=%h", op);
        end
        memreq_val = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    int t0, t1, r;
    initial begin
        reset = 1'b1; memreq_val = 0; memreq_type = 0; memreq_opaque = 0;
        memreq_addr = 0; memreq_len = 0; memreq_data = 0; memresp_rdy = 1'b1;
        stop_rnd = 0;
        idle(3);
        reset = 1'b0;
        for (int i = 0; i < 256; i++) send(3'd2, 32'(i * 4), 2'd0, $urandom, 8'(i));
        idle(3);

        // Write then read, back to back
        send(3'd1, 32'h10, 2'd0, 32'hDEADBEEF, 8'h01);
        send(3'd0, 32'h10, 2'd0, 32'h0, 8'h02);
        idle(3);
        chk("t1_write_data", 64'(act_data[8'h01]), 64'h0);
        chk("t1_read_data", 64'(act_data[8'h02]), 64'hDEADBEEF);

        // Subword write/read
        send(3'd1, 32'h20, 2'd0, 32'h11223344, 8'h10);
        send(3'd1, 32'h21, 2'd2, 32'h0000ABCD, 8'h11);
        send(3'd0, 32'h20, 2'd0, 32'h0, 8'h12);
        send(3'd0, 32'h22, 2'd1, 32'h0, 8'h13);
        idle(3);
        chk("t2_word", 64'(act_data[8'h12]), 64'h11ABCD44);
        chk("t2_byte", 64'(act_data[8'h13]), 64'h000000AB);

        // Back-pressure: third request waits for a dequeue
        memresp_rdy = 1'b0;
        pop_log.delete();
        fork
            begin
                send(3'd0, 32'h10, 2'd0, 0, 8'h00);
                send(3'd0, 32'h14, 2'd0, 0, 8'h01);
                send(3'd0, 32'h18, 2'd0, 0, 8'h02);
            end
            begin idle(6); memresp_rdy = 1'b1; end
        join
        idle(4);
        chk("t3_count", 64'(pop_log.size()), 64'd3);
        for (int i = 0; i < 3; i++)
            if (i < pop_log.size()) chk("t3_order", 64'(pop_log[i]), 64'(i));

        // Throughput at one per cycle
        t0 = cyc;
        for (int i = 0; i < 8; i++) send(3'd0, 32'(i * 4), 2'd0, 0, 8'(8'h40 + i));
        t1 = cyc;
        chk("t4_cycles", 64'(t1 - t0), 64'd8);
        idle(3);

        // Wrap-around and byte-3 boundary
        send(3'd1, 32'h400, 2'd0, 32'h5A5A5A5A, 8'h50);
        send(3'd0, 32'h0, 2'd0, 0, 8'h51);
        send(3'd1, 32'h3, 2'd0, 32'hFFFFFFFF, 8'h52);
        send(3'd0, 32'h0, 2'd0, 0, 8'h53);
        idle(3);
        chk("t5_wrap", 64'(act_data[8'h51]), 64'h5A5A5A5A);
        chk("t5_byte3", 64'(act_data[8'h53]), 64'hFF5A5A5A);

        // Reset with two queued responses
        memresp_rdy = 1'b0;
        send(3'd0, 32'h40, 2'd0, 0, 8'h60);
        send(3'd0, 32'h44, 2'd0, 0, 8'h61);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        @(negedge clk);
        chk("t6_val_after_rst", 64'(memresp_val), 64'd0);
        chk("t6_rdy_after_rst", 64'(memreq_rdy), 64'd1);
        @(posedge clk); #1;
        memresp_rdy = 1'b1;
        send(3'd0, 32'h10, 2'd0, 0, 8'h62);
        idle(3);
        chk("t6_array_kept", 64'(act_data[8'h62]), 64'hDEADBEEF);

        // Random traffic with random response back-pressure
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    r = $urandom_range(0, 9);
                    send((r < 4) ? 3'd0 : (r < 7) ? 3'd1 : (r < 8) ? 3'd2 : 3'($urandom_range(3, 7)),
                         $urandom, 2'($urandom), $urandom, 8'(i));
                end
                stop_rnd = 1;
            end
            begin
                while (!stop_rnd) begin
                    memresp_rdy = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
            end
        join
        memresp_rdy = 1'b1;
        idle(5);
        chk("drained", 64'(memresp_val), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
